// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic issue stage: operand width,
// FSM state encoding and compare-flag bit positions.
package arith_pkg;

   localparam int ARITH_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int CMP_EQ = 0;
   localparam int CMP_NE = 1;
   localparam int CMP_LT = 2;
   localparam int CMP_LE = 3;
   localparam int CMP_GE = 4;
   localparam int CMP_GT = 5;

   // A consistent flag vector always has each complementary pair differing.
   function automatic logic flags_bad(input logic [5:0] cmp);
      return (cmp[CMP_EQ] == cmp[CMP_NE]) ||
             (cmp[CMP_LT] == cmp[CMP_GE]) ||
             (cmp[CMP_GT] == cmp[CMP_LE]);
   endfunction

endpackage

// File: rtl/arith_opnd_fifo.sv
// Synchronous operand FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module arith_opnd_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign count    = wr_ptr_q - rd_ptr_q;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/arith_issue_stage.sv
// Issue stage in front of the combinational arith unit: operand FIFO, operand
// register, result register. Optional counters under ARITH_ISSUE_STATS_EN.
module arith_issue_stage
   import arith_pkg::*;
#(
   parameter int W     = ARITH_W,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic [W-1:0]   arith_a,
   output logic [W-1:0]   arith_b,
   input  logic [2*W-1:0] res_p,
   input  logic [2*W-1:0] res_q,
   input  logic [2*W-1:0] res_r,
   input  logic [5:0]     res_cmp,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_p,
   output logic [2*W-1:0] out_q,
   output logic [2*W-1:0] out_r,
   output logic [5:0]     out_cmp,
   output logic           err
`ifdef ARITH_ISSUE_STATS_EN
   ,
   output logic [15:0]    stat_cnt,
   output logic [15:0]    stat_stall
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid holds its payload stable until that edge.
   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic             out_valid_q, out_valid_d;
   logic [2*W-1:0]   out_p_q, out_p_d, out_q_q, out_q_d, out_r_q, out_r_d;
   logic [5:0]       out_cmp_q, out_cmp_d;
   logic             err_q, err_d;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [2*W-1:0]   fifo_head;
   logic [CNT_W-1:0] fifo_count;

   // in_ready comes straight from the FIFO pointer flops, so a pop in the same
   // cycle cannot open a slot for a push while full.
   assign in_ready = (fifo_count != CNT_W'(DEPTH));

   arith_opnd_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid && in_ready),
      .push_data ({in_a, in_b}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      out_p_d     = out_p_q;
      out_q_d     = out_q_q;
      out_r_d     = out_r_q;
      out_cmp_d   = out_cmp_q;
      err_d       = err_q;
      fifo_pop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               a_d      = fifo_head[2*W-1:W];
               b_d      = fifo_head[W-1:0];
               state_d  = EVAL;
            end
         end
         EVAL: begin
            out_p_d     = res_p;
            out_q_d     = res_q;
            out_r_d     = res_r;
            out_cmp_d   = res_cmp;
            out_valid_d = 1'b1;
            err_d       = err_q || flags_bad(res_cmp);
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  a_d      = fifo_head[2*W-1:W];
                  b_d      = fifo_head[W-1:0];
                  state_d  = EVAL;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_q_q     <= '0;
         out_r_q     <= '0;
         out_cmp_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         out_p_q     <= out_p_d;
         out_q_q     <= out_q_d;
         out_r_q     <= out_r_d;
         out_cmp_q   <= out_cmp_d;
         err_q       <= err_d;
      end
   end

   assign arith_a   = a_q;
   assign arith_b   = b_q;
   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_q     = out_q_q;
   assign out_r     = out_r_q;
   assign out_cmp   = out_cmp_q;
   assign err       = err_q;

   fifo_full_chk: assert property (@(posedge clk) disable iff (rst)
      fifo_full == (fifo_count == CNT_W'(DEPTH)));

`ifdef ARITH_ISSUE_STATS_EN
   logic [15:0] stat_cnt_q, stat_cnt_d, stat_stall_q, stat_stall_d;

   always_comb begin
      stat_cnt_d   = stat_cnt_q;
      stat_stall_d = stat_stall_q;
      if (out_valid_q && out_ready && (stat_cnt_q != 16'hFFFF))
         stat_cnt_d = stat_cnt_q + 16'd1;
      if (out_valid_q && !out_ready && (stat_stall_q != 16'hFFFF))
         stat_stall_d = stat_stall_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_cnt_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_cnt_q   <= stat_cnt_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_cnt   = stat_cnt_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_arith_issue_stage.sv
// Bench for arith_issue_stage: models the arith unit, scoreboards results.
// Build with ARITH_ISSUE_STATS_EN to also exercise the counters.
module tb_arith_issue_stage;
   import arith_pkg::*;

   localparam int W     = 4;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_ready, out_valid, out_ready, err;
   logic [W-1:0]   in_a, in_b, arith_a, arith_b;
   logic [2*W-1:0] res_p, res_q, res_r, out_p, out_q, out_r;
   logic [5:0]     res_cmp, out_cmp;
   logic           corrupt_en;
`ifdef ARITH_ISSUE_STATS_EN
   logic [15:0]    stat_cnt, stat_stall;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [29:0] exp_q[$];
   int          hs_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   arith_issue_stage #(.W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .arith_a   (arith_a),
      .arith_b   (arith_b),
      .res_p     (res_p),
      .res_q     (res_q),
      .res_r     (res_r),
      .res_cmp   (res_cmp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_q     (out_q),
      .out_r     (out_r),
      .out_cmp   (out_cmp),
      .err       (err)
`ifdef ARITH_ISSUE_STATS_EN
      ,
      .stat_cnt  (stat_cnt),
      .stat_stall(stat_stall)
`endif
   );

   // Reference arith unit: {sum, diff, prod, {gt,ge,le,lt,ne,eq}}.
   function automatic logic [29:0] unit_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic corrupt);
      logic [7:0] p, q, r;
      logic [5:0] c;
      p = {4'b0, a} + {4'b0, b};
      q = {4'b0, a} - {4'b0, b};
      r = {4'b0, a} * {4'b0, b};
      c[0] = (a == b);
      c[1] = (a != b);
      c[2] = (a < b);
      c[3] = (a <= b);
      c[4] = (a >= b);
      c[5] = (a > b);
      if (corrupt) c[0] = 1'b1;
      return {p, q, r, c};
   endfunction

   assign {res_p, res_q, res_r, res_cmp} =
      unit_model(arith_a, arith_b, corrupt_en && (arith_a == 4'd7) && (arith_b == 4'd2));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   // Scoreboard side: compare every accepted result against the queue head.
   always @(negedge clk) begin
      logic [29:0] e;
      #1;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_p", 32'(out_p), 32'(e[29:22]));
            check("out_q", 32'(out_q), 32'(e[21:14]));
            check("out_r", 32'(out_r), 32'(e[13:6]));
            check("out_cmp", 32'(out_cmp), 32'(e[5:0]));
         end
         hs_cyc.push_back(cyc);
      end
   end

   // Called at a negedge; returns at the negedge after the pair was accepted.
   task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("push_timeout", 32'd0, 32'd1);
      else exp_q.push_back(unit_model(a, b, corrupt_en && a == 4'd7 && b == 4'd2));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Waits for out_valid, stalls for k edges, then accepts.
   task automatic deliver(input int k);
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("deliver_timeout", 32'd0, 32'd1);
      repeat (k) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int n_hs;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      out_ready  = 1'b1;
      corrupt_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_arith_a", 32'(arith_a), 32'd0);
      check("rst_arith_b", 32'(arith_b), 32'd0);
      check("rst_out_p", 32'(out_p), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single pair, latency check against hand-computed results.
      in_valid = 1'b1;
      in_a     = 4'd3;
      in_b     = 4'd5;
      exp_q.push_back(unit_model(4'd3, 4'd5, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_valid_n", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("t1_arith_a", 32'(arith_a), 32'd3);
      check("t1_arith_b", 32'(arith_b), 32'd5);
      check("t1_valid_n1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_n2", 32'(out_valid), 32'd1);
      check("t1_out_p", 32'(out_p), 32'd8);
      check("t1_out_q", 32'(out_q), 32'hFE);
      check("t1_out_r", 32'(out_r), 32'd15);
      check("t1_out_cmp", 32'(out_cmp), 32'b001110);
      check("t1_err", 32'(err), 32'd0);
      wait_drain();

      // Fill the FIFO with the consumer stalled; the extra pair must be held.
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) push_pair(4'(i + 1), 4'(i * 3));
      in_valid = 1'b1;
      in_a     = 4'd9;
      in_b     = 4'd4;
      repeat (2) @(negedge clk);
      check("t2_full_ready", 32'(in_ready), 32'd0);
      check("t2_none_out", 32'(exp_q.size()), 32'(DEPTH + 1));
      out_ready = 1'b1;
      push_pair(4'd9, 4'd4);
      wait_drain();

      // Back-to-back results two cycles apart.
      hs_cyc.delete();
      push_pair(4'd15, 4'd15);
      push_pair(4'd0, 4'd1);
      wait_drain();
      check("t3_count", 32'(hs_cyc.size()), 32'd2);
      if (hs_cyc.size() == 2) check("t3_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);

      // Corrupted flags set a sticky error; the result is still delivered.
      corrupt_en = 1'b1;
      push_pair(4'd7, 4'd2);
      wait_drain();
      check("t4_err_set", 32'(err), 32'd1);
      corrupt_en = 1'b0;
      push_pair(4'd4, 4'd4);
      push_pair(4'd2, 4'd9);
      wait_drain();
      check("t4_err_sticky", 32'(err), 32'd1);

      // Reset while evaluating with two pairs queued.
      out_ready = 1'b0;
      push_pair(4'd1, 4'd2);
      push_pair(4'd3, 4'd3);
      push_pair(4'd5, 4'd1);
      push_pair(4'd6, 4'd2);
      out_ready = 1'b1;
      @(negedge clk);
      check("t5_in_eval", 32'(dut.state_q), 32'(EVAL));
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
      check("t5_err", 32'(err), 32'd0);
      rst  = 1'b0;
      n_hs = hs_cyc.size();
      repeat (10) @(negedge clk);
      check("t5_quiet_valid", 32'(out_valid), 32'd0);
      check("t5_quiet_hs", 32'(hs_cyc.size()), 32'(n_hs));

      // Three results with 2+1+1 stall cycles.
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b0;
      push_pair(4'd2, 4'd3);
      deliver(2);
      push_pair(4'd8, 4'd1);
      deliver(1);
      push_pair(4'd5, 4'd5);
      deliver(1);
      repeat (2) @(negedge clk);
      check("t6_drained", 32'(exp_q.size()), 32'd0);
`ifdef ARITH_ISSUE_STATS_EN
      check("t6_stat_cnt", 32'(stat_cnt), 32'd3);
      check("t6_stat_stall", 32'(stat_stall), 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
